mem_port_arbiter: RTL

//  Parametrised N-port arbiter and timing controller for one asynchronous SRAM bank.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// N-port arbiter and timing sequencer for one asynchronous SRAM bank.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module mem_port_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*32-1:0]         addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] be,
  output logic [NUM_PORTS-1:0]            ack,
  output logic [DATA_W-1:0]               rdata,
  output logic                            busy,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_dq_o,
  output logic                            ram_dq_oe,
  input  logic [DATA_W-1:0]               ram_dq_i,
  output logic [DATA_W/8-1:0]             ram_be_n,
  output logic                            ram_ce_n,
  output logic                            ram_oe_n,
  output logic                            ram_we_n
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW   = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] p_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] p_wdata;
  logic [NUM_PORTS-1:0][BE_W-1:0]   p_be;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign p_addr[i]  = addr[32*i+2 +: ADDR_W];
    assign p_wdata[i] = wdata[DATA_W*i +: DATA_W];
    assign p_be[i]    = be[BE_W*i +: BE_W];
  end

  // Byte-offset and out-of-bank address bits are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       win_q, grant_idx;
  logic                grant_vld, start;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                act, rd_cap_q;

  logic [NUM_PORTS-1:0] ack_q;
  logic [DATA_W-1:0]    rdata_q, dq_o_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic [BE_W-1:0]      be_n_q;
  logic                 busy_q, dq_oe_q, ce_n_q, oe_n_q, we_n_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr_q, rr_sel;

  // Walk from farthest to nearest so the port just after rr_ptr wins last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sel    = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      rr_sel = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (req[rr_sel]) begin
        grant_vld = 1'b1;
        grant_idx = rr_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)       rr_ptr_q <= PW'(NUM_PORTS - 1);
    else if (start) rr_ptr_q <= grant_idx;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[PW'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end
`endif

  // The idle cycle that carries the ack still sees the old req, so it never arbitrates.
  assign start = (state_q == IDLE) && grant_vld && (ack_q == '0);
  assign act   = (state_q == SETUP) || (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CW'(WAIT_CYCLES - 1);
      end
      ACCESS:  if (cnt_q == '0) state_d = DONE;
               else             cnt_d   = cnt_q - 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_cap_q   <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      ram_addr_q <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      be_n_q     <= '1;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        win_q   <= grant_idx;
        we_q    <= we[grant_idx];
        addr_q  <= p_addr[grant_idx];
        wdata_q <= p_wdata[grant_idx];
        be_q    <= p_be[grant_idx];
      end
      // Pins are a registered decode of the current state, one cycle behind it.
      busy_q  <= (state_q != IDLE);
      ce_n_q  <= !act;
      oe_n_q  <= !(act && !we_q);
      we_n_q  <= !((state_q == ACCESS) && we_q && (be_q != '0));
      dq_oe_q <= (state_q != IDLE) && we_q;
      if (act && !we_q)                 be_n_q <= '0;
      else if (state_q != IDLE && we_q) be_n_q <= ~be_q;
      else                              be_n_q <= '1;
      if (state_q != IDLE)         ram_addr_q <= addr_q;
      if (state_q != IDLE && we_q) dq_o_q     <= wdata_q;
      ack_q <= '0;
      if (state_q == DONE) ack_q[win_q] <= 1'b1;
      // Sample the bus while the pins show the last access cycle.
      rd_cap_q <= (state_q == ACCESS) && (cnt_q == '0) && !we_q;
      if (rd_cap_q) rdata_q <= ram_dq_i;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dq_o  = dq_o_q;
  assign ram_dq_oe = dq_oe_q;
  assign ram_be_n  = be_n_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
endmodule
